// File: rtl/fifo_fill_pkg.sv
// Shared definitions for the DDR-to-video-FIFO burst fill controller.
//   state_t   : controller state encoding
//   LEN_W     : width of the read-command length field (beats-1)
//   cnt_width : width of the credit / outstanding-beat arithmetic. Two
//               bits above the FIFO depth width leave room for a full FIFO
//               plus a burst still in flight.
package fifo_fill_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_ISSUE = 3'd2,
        S_CMD   = 3'd3,
        S_TAIL  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    localparam int LEN_W = 8;

    function automatic int cnt_width(input int depth_width);
        return depth_width + 2;
    endfunction

endpackage

// File: rtl/fifo_credit_cnt.sv
// Outstanding-beat counter and credit check for the burst fill controller.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   add_en       : a read command handshake happened this cycle
//   add_beats    : beats requested by that command
//   wr_done      : a beat is being written into the FIFO this cycle
//   drop         : a returned beat was discarded this cycle
//   water_level  : FIFO write-side fill level
//   need_beats   : size of the burst the controller wants to issue next
//   outstanding  : beats requested but not yet visible in water_level
//   credit_ok    : free space (depth - level - outstanding) >= need_beats
module fifo_credit_cnt
    import fifo_fill_pkg::*;
#(
    parameter int DEPTH_WIDTH = 10,
    parameter int LEVEL_LAT   = 1,
    localparam int CW         = cnt_width(DEPTH_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   add_en,
    input  logic [LEN_W:0]         add_beats,
    input  logic                   wr_done,
    input  logic                   drop,
    input  logic [DEPTH_WIDTH:0]   water_level,
    input  logic [LEN_W:0]         need_beats,
    output logic [CW-1:0]          outstanding,
    output logic                   credit_ok
);

    localparam int CW1   = CW + 1;
    localparam int CAP_I = 1 << DEPTH_WIDTH;
    localparam logic [CW1-1:0] CAP = CW1'(CAP_I);

    // A written beat stays counted here until the FIFO level has had
    // LEVEL_LAT cycles to reflect it, so it is never missing from both.
    logic [LEVEL_LAT-1:0] wr_dly;

    generate
        if (LEVEL_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) wr_dly <= '0;
                else        wr_dly <= wr_done;
            end
        end else begin : g_latn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) wr_dly <= '0;
                else        wr_dly <= {wr_dly[LEVEL_LAT-2:0], wr_done};
            end
        end
    endgenerate

    logic [CW-1:0]  add_amt;
    logic [CW-1:0]  dec_amt;
    logic [CW1-1:0] sum;
    logic [CW1-1:0] used;
    logic [CW1-1:0] credit;

    always_comb begin
        add_amt   = add_en ? CW'(add_beats) : '0;
        // Up to two decrements per cycle: one delayed write, one discard.
        dec_amt   = CW'(wr_dly[LEVEL_LAT-1]) + CW'(drop);
        sum       = {1'b0, outstanding} + {1'b0, add_amt};
        used      = CW1'(water_level) + {1'b0, outstanding};
        // Saturate at zero: level + outstanding may transiently exceed depth.
        credit    = (used >= CAP) ? '0 : CAP - used;
        credit_ok = (credit >= CW1'(need_beats));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            outstanding <= (sum > {1'b0, dec_amt}) ? CW'(sum - {1'b0, dec_amt}) : '0;
        end
    end

endmodule

// File: rtl/fifo_burst_fill_ctrl.sv
// Read-burst scheduler keeping the video FIFO filled from DDR for one frame.
// Issues fixed-length read commands only when the FIFO can absorb a whole
// burst, forwards returned beats to the FIFO write port, and sequences
// frame start (flush), end of frame and abort on a new frame start.
// Ports:
//   clk, rst_n            : DDR user clock, async active-low reset
//   enable, frame_start   : frame_start accepted only while enable=1
//   base_addr             : frame base byte address
//   rd_cmd_valid/ready    : read command handshake
//   rd_cmd_addr/len       : burst start address, beats-1
//   rd_data_valid/rd_data : returned beats
//   fifo_wr_en/data       : FIFO write port (1-cycle registered)
//   fifo_wr_full          : FIFO full
//   fifo_wr_water_level   : FIFO write-side fill level
//   fifo_flush            : FIFO reset request
//   busy                  : controller not idle
//   frame_done            : pulse after the last beat of the frame
//   overflow_err          : sticky beat-loss flag
module fifo_burst_fill_ctrl
    import fifo_fill_pkg::*;
#(
    parameter int DEPTH_WIDTH    = 10,
    parameter int DATA_WIDTH     = 256,
    parameter int ADDR_WIDTH     = 28,
    parameter int BURST_LEN      = 16,
    parameter int BYTES_PER_BEAT = 32,
    parameter int FRAME_BEATS    = 32400,
    parameter int FLUSH_CYCLES   = 8,
    parameter int LEVEL_LAT      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   frame_start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    output logic                   rd_cmd_valid,
    input  logic                   rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0]  rd_cmd_addr,
    output logic [7:0]             rd_cmd_len,
    input  logic                   rd_data_valid,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   fifo_wr_en,
    output logic [DATA_WIDTH-1:0]  fifo_wr_data,
    input  logic                   fifo_wr_full,
    input  logic [DEPTH_WIDTH:0]   fifo_wr_water_level,
    output logic                   fifo_flush,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overflow_err
);

    localparam int BW   = LEN_W + 1;
    localparam int IW   = $clog2(FRAME_BEATS + 1);
    localparam int RW   = (IW > BW) ? IW : BW;
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int CW   = cnt_width(DEPTH_WIDTH);

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] base_pend;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_W-1:0]      cmd_len;
    logic [BW-1:0]         cmd_beats;
    logic [BW-1:0]         burst_beats;
    logic [IW-1:0]         issued;
    logic [RW-1:0]         remaining;
    logic [FC_W-1:0]       flush_cnt;
    logic                  abort_pend;
    logic                  overflow_q;
    logic                  frame_done_q;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [CW-1:0]         outstanding;
    logic                  credit_ok;

    logic start_ok, cmd_fire, flush_last, frame_issued, out_zero;
    logic abort_zone, beat_known, write_beat, drop_beat, ovf_evt, enter_flush;

    assign rd_cmd_addr  = cmd_addr;
    assign rd_cmd_len   = cmd_len;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign frame_done   = frame_done_q;
    assign overflow_err = overflow_q;

    always_comb begin
        start_ok     = frame_start && enable;
        cmd_fire     = (state == S_CMD) && rd_cmd_ready;
        flush_last   = (flush_cnt == FC_W'(FLUSH_CYCLES - 1));
        frame_issued = (issued == IW'(FRAME_BEATS));
        out_zero     = (outstanding == '0);
        remaining    = RW'(FRAME_BEATS) - RW'(issued);
        // The last burst of a frame is shortened to what is left.
        burst_beats  = (remaining < RW'(BURST_LEN)) ? BW'(remaining) : BW'(BURST_LEN);
    end

    fifo_credit_cnt #(
        .DEPTH_WIDTH (DEPTH_WIDTH),
        .LEVEL_LAT   (LEVEL_LAT)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .add_en      (cmd_fire),
        .add_beats   (cmd_beats),
        .wr_done     (wr_en_q),
        .drop        (drop_beat),
        .water_level (fifo_wr_water_level),
        .need_beats  (burst_beats),
        .outstanding (outstanding),
        .credit_ok   (credit_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        rd_cmd_valid = 1'b0;
        fifo_flush   = 1'b0;
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_ok) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                fifo_flush = 1'b1;
                // A new frame_start here restarts the flush count.
                if (!start_ok && flush_last) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (start_ok)          state_next = S_ABORT;
                else if (frame_issued) state_next = S_TAIL;
                else if (credit_ok)    state_next = S_CMD;
            end
            S_CMD: begin
                rd_cmd_valid = 1'b1;
                // The command is never withdrawn; an abort waits for the handshake.
                if (rd_cmd_ready) state_next = (abort_pend || start_ok) ? S_ABORT : S_ISSUE;
            end
            S_TAIL: begin
                if (start_ok)      state_next = S_ABORT;
                else if (out_zero) state_next = S_IDLE;
            end
            S_ABORT: begin
                if (out_zero) state_next = S_FLUSH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Beat classification: a beat with nothing outstanding or arriving while
    // the FIFO is full is lost; beats of an aborted frame are drained silently.
    always_comb begin
        abort_zone  = (state == S_ABORT) || (state_next == S_ABORT);
        beat_known  = rd_data_valid && !out_zero;
        write_beat  = beat_known && !fifo_wr_full && !abort_zone;
        drop_beat   = beat_known && !write_beat;
        ovf_evt     = rd_data_valid && (fifo_wr_full || out_zero);
        enter_flush = (state_next == S_FLUSH) && ((state != S_FLUSH) || start_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_addr    <= '0;
            base_pend    <= '0;
            cmd_addr     <= '0;
            cmd_len      <= '0;
            cmd_beats    <= '0;
            issued       <= '0;
            flush_cnt    <= '0;
            abort_pend   <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
        end else begin
            frame_done_q <= (state == S_TAIL) && (state_next == S_IDLE);
            wr_en_q      <= write_beat;
            if (rd_data_valid) wr_data_q <= rd_data;

            abort_pend <= (state == S_CMD) && !rd_cmd_ready && (abort_pend || start_ok);

            if (start_ok) begin
                overflow_q <= 1'b0;
                base_pend  <= base_addr;
            end else if (ovf_evt) begin
                overflow_q <= 1'b1;
            end

            if (enter_flush) begin
                flush_cnt <= '0;
                issued    <= '0;
                next_addr <= start_ok ? base_addr : base_pend;
            end else if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt + FC_W'(1);
            end

            if ((state == S_ISSUE) && (state_next == S_CMD)) begin
                cmd_addr  <= next_addr;
                cmd_len   <= LEN_W'(burst_beats - BW'(1));
                cmd_beats <= burst_beats;
            end

            if (cmd_fire) begin
                next_addr <= next_addr + ADDR_WIDTH'(cmd_beats) * ADDR_WIDTH'(BYTES_PER_BEAT);
                issued    <= issued + IW'(cmd_beats);
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_fill_ctrl.sv
module tb_fifo_burst_fill_ctrl;

    localparam int DW = 10;
    localparam int AW = 28;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          rd_cmd_valid;
    logic          rd_cmd_ready = 1'b0;
    logic [AW-1:0] rd_cmd_addr;
    logic [7:0]    rd_cmd_len;
    logic          rd_data_valid = 1'b0;
    logic [255:0]  rd_data = '0;
    logic          fifo_wr_en;
    logic [255:0]  fifo_wr_data;
    logic          fifo_wr_full = 1'b0;
    logic [DW:0]   level = '0;
    logic          fifo_flush;
    logic          busy;
    logic          frame_done;
    logic          overflow_err;

    always #5 clk = ~clk;

    fifo_burst_fill_ctrl #(
        .DEPTH_WIDTH(DW), .DATA_WIDTH(256), .ADDR_WIDTH(AW), .BURST_LEN(16),
        .BYTES_PER_BEAT(32), .FRAME_BEATS(40), .FLUSH_CYCLES(8), .LEVEL_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
        .base_addr(base_addr), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_data_valid(rd_data_valid),
        .rd_data(rd_data), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_wr_full(fifo_wr_full), .fifo_wr_water_level(level), .fifo_flush(fifo_flush),
        .busy(busy), .frame_done(frame_done), .overflow_err(overflow_err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Monitor / DDR responder state (written only by the monitor process)
    int            cmd_cnt, wr_cnt, done_cnt, flush_cyc, data_err, sent_cnt;
    logic [AW-1:0] log_addr[$];
    int            log_len[$];
    int            pend_due[$];
    int            pend_beats[$];
    int            cur_left, cyc, clr_seen, inj_seen;
    logic [31:0]   beat_id;

    // Requests from the main process
    int resp_lat = 4;
    int clr_seq = 0;
    int inj_seq = 0;

    initial begin
        cmd_cnt = 0; wr_cnt = 0; done_cnt = 0; flush_cyc = 0; data_err = 0; sent_cnt = 0;
        cur_left = 0; cyc = 0; clr_seen = 0; inj_seen = 0; beat_id = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_seq != clr_seen) begin
                clr_seen = clr_seq;
                cmd_cnt = 0; wr_cnt = 0; done_cnt = 0; flush_cyc = 0; data_err = 0; sent_cnt = 0;
                cur_left = 0;
                log_addr.delete(); log_len.delete(); pend_due.delete(); pend_beats.delete();
            end
            // rd_data still holds the beat of the previous cycle here
            if (fifo_wr_en) begin
                wr_cnt++;
                if (!rd_data_valid || fifo_wr_data !== rd_data) data_err++;
            end
            if (frame_done) done_cnt++;
            if (fifo_flush) flush_cyc++;
            if (rd_cmd_valid && rd_cmd_ready) begin
                cmd_cnt++;
                log_addr.push_back(rd_cmd_addr);
                log_len.push_back(int'(rd_cmd_len));
                pend_due.push_back(cyc + resp_lat);
                pend_beats.push_back(int'(rd_cmd_len) + 1);
            end
            if (cur_left == 0 && pend_due.size() > 0) begin
                if (pend_due[0] <= cyc) begin
                    cur_left = pend_beats.pop_front();
                    void'(pend_due.pop_front());
                end
            end
            if (cur_left > 0) begin
                beat_id++;
                rd_data_valid = 1'b1;
                rd_data = {8{beat_id}};
                cur_left--;
                sent_cnt++;
            end else if (inj_seq != inj_seen) begin
                inj_seen = inj_seq;
                beat_id++;
                rd_data_valid = 1'b1;
                rd_data = {8{beat_id}};
            end else begin
                rd_data_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0; frame_start = 1'b0; rd_cmd_ready = 1'b0;
        fifo_wr_full = 1'b0; level = '0; resp_lat = 4;
        clr_seq++;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic start(input logic [AW-1:0] b);
        base_addr = b; enable = 1'b1; frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int i = 0; i < bound && done_cnt == 0; i++) tick(1);
        chk(name, done_cnt > 0, 1);
    endtask

    task automatic wait_cmds(input string name, input int n, input int bound);
        for (int i = 0; i < bound && cmd_cnt < n; i++) tick(1);
        chk(name, cmd_cnt >= n, 1);
    endtask

    typedef struct {
        logic [DW:0] lvl;
        logic        exp_cmd;
    } cvec_t;

    cvec_t cv[6];

    logic [AW-1:0] a0;
    logic [7:0]    l0;
    int            unstable;
    int            fl0;

    initial begin
        cv[0] = '{11'd1010, 1'b0};  // credit 14
        cv[1] = '{11'd1009, 1'b0};  // credit 15
        cv[2] = '{11'd1008, 1'b1};  // credit 16, exactly one burst
        cv[3] = '{11'd0,    1'b1};
        cv[4] = '{11'd1024, 1'b0};  // full
        cv[5] = '{11'd2047, 1'b0};  // level above depth: no credit underflow

        // Reset state
        do_reset();
        chk("rst_cmd_valid", rd_cmd_valid, 0);
        chk("rst_cmd_addr", rd_cmd_addr, 0);
        chk("rst_cmd_len", rd_cmd_len, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_flush", fifo_flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow_err, 0);

        // Whole frame: 40 beats -> bursts of 16,16,8
        rd_cmd_ready = 1'b1;
        start(28'h100_0000);
        chk("busy_after_start", busy, 1);
        chk("flush_active", fifo_flush, 1);
        wait_done("frame_done_timeout", 400);
        tick(5);
        chk("frame_cmds", cmd_cnt, 3);
        chk("addr0", log_addr.size() > 0 ? log_addr[0] : 28'hFFF_FFFF, 28'h100_0000);
        chk("addr1", log_addr.size() > 1 ? log_addr[1] : 28'hFFF_FFFF, 28'h100_0200);
        chk("addr2", log_addr.size() > 2 ? log_addr[2] : 28'hFFF_FFFF, 28'h100_0400);
        chk("len0", log_len.size() > 0 ? log_len[0] : -1, 15);
        chk("len1", log_len.size() > 1 ? log_len[1] : -1, 15);
        chk("len2", log_len.size() > 2 ? log_len[2] : -1, 7);
        chk("frame_beats_written", wr_cnt, 40);
        chk("write_data", data_err, 0);
        chk("frame_done_once", done_cnt, 1);
        chk("flush_cycles", flush_cyc, 8);
        chk("idle_after_frame", busy, 0);
        chk("no_overflow", overflow_err, 0);

        // Credit threshold table (command held pending with ready=0)
        for (int k = 0; k < 6; k++) begin
            do_reset();
            level = cv[k].lvl;
            start(28'h020_0000);
            tick(12);
            chk($sformatf("credit_lvl%0d", cv[k].lvl), rd_cmd_valid, cv[k].exp_cmd);
            if (cv[k].exp_cmd) begin
                chk($sformatf("credit_addr_lvl%0d", cv[k].lvl), rd_cmd_addr, 28'h020_0000);
                chk($sformatf("credit_len_lvl%0d", cv[k].lvl), rd_cmd_len, 15);
            end
        end

        // Level drops from 1010 to 1008 -> command within 2 cycles
        do_reset();
        level = 11'd1010;
        start(28'h000_4000);
        tick(20);
        chk("lvl1010_no_cmd", rd_cmd_valid, 0);
        level = 11'd1008;
        tick(2);
        chk("lvl1008_cmd", rd_cmd_valid, 1);

        // Ready held low 10 cycles: command stays stable, one handshake
        do_reset();
        start(28'h030_0000);
        tick(12);
        chk("stall_valid", rd_cmd_valid, 1);
        a0 = rd_cmd_addr; l0 = rd_cmd_len; unstable = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!rd_cmd_valid || rd_cmd_addr !== a0 || rd_cmd_len !== l0) unstable++;
        end
        chk("stall_stable", unstable, 0);
        chk("stall_no_hs", cmd_cnt, 0);
        rd_cmd_ready = 1'b1;
        tick(1);
        rd_cmd_ready = 1'b0;
        chk("stall_one_hs", cmd_cnt, 1);
        tick(3);
        chk("stall_still_one", cmd_cnt, 1);
        chk("stall_next_addr", rd_cmd_addr, 28'h030_0200);

        // Abort with 32 beats outstanding
        do_reset();
        level = 11'd992;
        resp_lat = 20;
        rd_cmd_ready = 1'b1;
        start(28'h040_0000);
        wait_cmds("abort_two_cmds", 2, 60);
        tick(2);
        chk("abort_credit_blocks", rd_cmd_valid, 0);
        fl0 = flush_cyc;
        start(28'h050_0000);
        for (int i = 0; i < 200 && !fifo_flush; i++) tick(1);
        chk("abort_flush_seen", fifo_flush, 1);
        chk("abort_no_new_cmd", cmd_cnt, 2);
        chk("abort_beats_returned", sent_cnt, 32);
        chk("abort_beats_dropped", wr_cnt, 0);
        wait_cmds("abort_new_cmd", 3, 60);
        chk("abort_flush_len", flush_cyc - fl0, 8);
        chk("abort_new_base", log_addr.size() > 2 ? log_addr[2] : 28'hFFF_FFFF, 28'h050_0000);
        chk("abort_no_ovf", overflow_err, 0);

        // Overflow: stray beat, ignored start, clear, full FIFO
        do_reset();
        tick(2);
        inj_seq++;
        tick(3);
        chk("stray_beat_ovf", overflow_err, 1);
        chk("stray_beat_not_written", wr_cnt, 0);
        base_addr = 28'h060_0000; enable = 1'b0; frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(2);
        chk("disabled_start_busy", busy, 0);
        chk("disabled_start_ovf", overflow_err, 1);
        rd_cmd_ready = 1'b1;
        fifo_wr_full = 1'b1;
        start(28'h060_0000);
        chk("start_clears_ovf", overflow_err, 0);
        wait_done("full_frame_done", 400);
        chk("full_no_writes", wr_cnt, 0);
        chk("full_ovf_set", overflow_err, 1);
        fifo_wr_full = 1'b0;
        tick(5);
        chk("ovf_sticky", overflow_err, 1);

        // Asynchronous reset in the middle of a pending command
        do_reset();
        inj_seq++;
        tick(2);
        start(28'h070_0000);
        tick(12);
        chk("pre_rst_valid", rd_cmd_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cmd_valid", rd_cmd_valid, 0);
        chk("arst_cmd_addr", rd_cmd_addr, 0);
        chk("arst_cmd_len", rd_cmd_len, 0);
        chk("arst_wr_en", fifo_wr_en, 0);
        chk("arst_wr_data", fifo_wr_data == '0, 1);
        chk("arst_flush", fifo_flush, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_ovf", overflow_err, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
